game_controller: RTL and testbench

- Top-level game sequencer for the FlippyBit game, parametrised in lane count, score width, life count and level pacing.
- Consumes per-lane `game_over` and `correct` flags from the lane blocks.
- Drives the lane clear pulse (`reset_signal`), score, best score, remaining lives and difficulty level to the display and lane logic.
- Adds to the original three-lane scorer:
  - explicit idle and game-over states;
  - multiple lives;
  - multi-lane scoring in one cycle;
  - saturation;
  - best-score tracking.

---
 rtl/game_controller.sv | 155 +++++++++++++++
 tb/tb_game_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// FlippyBit game sequencer: runs idle/clear/play/miss/over phases, keeps score,
// best score, lives and difficulty level for the lane and display logic.
module game_controller #(
  parameter int LANES      = 3,
  parameter int SCORE_W    = 8,
  parameter int LIVES      = 3,
  parameter int OVER_HOLD  = 50000000,
  parameter int LEVEL_STEP = 10
) (
  input  logic                         clock,
  input  logic                         reset_button,
  input  logic                         start,
  input  logic [LANES-1:0]             game_over,
  input  logic [LANES-1:0]             correct,
  output logic                         reset_signal,
  output logic [SCORE_W-1:0]           score,
  output logic [SCORE_W-1:0]           best_score,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [3:0]                   level,
  output logic                         new_best,
  output logic                         playing,
  output logic                         over
);

  localparam int LIFE_W = $clog2(LIVES + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(OVER_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_POINT = 3'd3,
    S_MISS  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t               state_r, state_next_s;
  logic [SCORE_W-1:0]   score_r, best_r, score_add_s;
  logic [LIFE_W-1:0]    lives_r;
  logic [3:0]           level_r, level_next_s;
  logic                 new_best_r;
  logic [HOLD_W-1:0]    hold_cnt_r;
  logic [CNT_W-1:0]     hits_s;
  logic [SCORE_W:0]     sum_s;
  logic [31:0]          quot_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Saturating score increment and level derived from the current score.
  always_comb begin
    hits_s = popcount(correct);
    sum_s  = {1'b0, score_r} + (SCORE_W + 1)'(hits_s);
    if (sum_s > {1'b0, SCORE_MAX}) begin
      score_add_s = SCORE_MAX;
    end else begin
      score_add_s = sum_s[SCORE_W-1:0];
    end
    quot_s = 32'(score_r) / 32'(LEVEL_STEP);
    if (quot_s > 32'd15) begin
      level_next_s = 4'd15;
    end else begin
      level_next_s = quot_s[3:0];
    end
  end

  // Next-state decode; a miss outranks a hit in the same cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  if (start) state_next_s = S_CLEAR; else state_next_s = S_IDLE;
      S_CLEAR: state_next_s = S_RUN;
      S_RUN: begin
        if (|game_over)    state_next_s = S_MISS;
        else if (|correct) state_next_s = S_POINT;
        else               state_next_s = S_RUN;
      end
      S_POINT: state_next_s = S_RUN;
      S_MISS:  if (lives_r == {LIFE_W{1'b0}}) state_next_s = S_OVER; else state_next_s = S_RUN;
      S_OVER:  if (hold_cnt_r == HOLD_LAST) state_next_s = S_IDLE; else state_next_s = S_OVER;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset_button) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Score, lives, best-score and hold-counter bookkeeping.
  always_ff @(posedge clock) begin
    if (reset_button) begin
      score_r    <= {SCORE_W{1'b0}};
      best_r     <= {SCORE_W{1'b0}};
      lives_r    <= LIFE_W'(LIVES);
      level_r    <= 4'd0;
      new_best_r <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      level_r <= level_next_s;
      case (state_r)
        S_CLEAR: begin
          score_r    <= {SCORE_W{1'b0}};
          lives_r    <= LIFE_W'(LIVES);
          level_r    <= 4'd0;
          new_best_r <= 1'b0;
          hold_cnt_r <= {HOLD_W{1'b0}};
        end
        S_RUN: begin
          if (|game_over) begin
            if (lives_r != {LIFE_W{1'b0}}) lives_r <= lives_r - LIFE_W'(1'b1);
          end else if (|correct) begin
            score_r <= score_add_s;
          end
        end
        S_MISS: begin
          if ((lives_r == {LIFE_W{1'b0}}) && (score_r > best_r)) begin
            best_r     <= score_r;
            new_best_r <= 1'b1;
          end
        end
        S_OVER: begin
          if (hold_cnt_r == HOLD_LAST) hold_cnt_r <= {HOLD_W{1'b0}};
          else                         hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
        end
        default: begin
          hold_cnt_r <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  assign reset_signal = (state_r == S_CLEAR) || (state_r == S_MISS);
  assign playing      = (state_r == S_RUN) || (state_r == S_POINT) || (state_r == S_MISS);
  assign over         = (state_r == S_OVER);
  assign score        = score_r;
  assign best_score   = best_r;
  assign lives        = lives_r;
  assign level        = level_r;
  assign new_best     = new_best_r;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus random games
// checked against an event-level model of score, lives and best score.
module tb_game_controller;
  localparam int LANES = 3, SCORE_W = 8, LIVES = 3, OVER_HOLD = 4, LEVEL_STEP = 4;

  logic clock = 1'b0;
  logic reset_button, start;
  logic [2:0] game_over, correct;
  logic reset_signal, new_best, playing, over;
  logic [7:0] score, best_score;
  logic [1:0] lives;
  logic [3:0] level;

  int total = 0, bad = 0;
  int m_score, m_best, m_lives;
  bit m_new_best;

  game_controller #(.LANES(LANES), .SCORE_W(SCORE_W), .LIVES(LIVES),
                    .OVER_HOLD(OVER_HOLD), .LEVEL_STEP(LEVEL_STEP)) dut (
    .clock(clock), .reset_button(reset_button), .start(start),
    .game_over(game_over), .correct(correct), .reset_signal(reset_signal),
    .score(score), .best_score(best_score), .lives(lives), .level(level),
    .new_best(new_best), .playing(playing), .over(over));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int pop(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  function automatic int exp_level();
    return (m_score / LEVEL_STEP > 15) ? 15 : m_score / LEVEL_STEP;
  endfunction

  task automatic test_reset();
    reset_button = 1'b1; start = 1'b0; game_over = 3'd0; correct = 3'd0;
    tick(); tick();
    reset_button = 1'b0;
    m_score = 0; m_best = 0; m_lives = LIVES; m_new_best = 1'b0;
    total++; if ({playing, over, reset_signal, new_best} !== 4'b0000) begin bad++; $display("FAIL reset.flags got=%b exp=0000", {playing, over, reset_signal, new_best}); end
    total++; if ({score, best_score} !== 16'h0000) begin bad++; $display("FAIL reset.scores got=%0d/%0d exp=0/0", score, best_score); end
    total++; if ({lives, level} !== {2'd3, 4'd0}) begin bad++; $display("FAIL reset.lives_level got=%0d/%0d exp=3/0", lives, level); end
    tick(); tick();
    total++; if ({playing, over, reset_signal} !== 3'b000) begin bad++; $display("FAIL idle.hold got=%b exp=000", {playing, over, reset_signal}); end
  endtask

  task automatic begin_game();
    start = 1'b1; tick();
    total++; if ({playing, over, reset_signal} !== 3'b001) begin bad++; $display("FAIL start.clear got=%b exp=001", {playing, over, reset_signal}); end
    start = 1'b0; m_score = 0; m_lives = LIVES; m_new_best = 1'b0;
    tick();
    total++; if ({playing, over, reset_signal} !== 3'b100) begin bad++; $display("FAIL start.run got=%b exp=100", {playing, over, reset_signal}); end
    total++; if ({score, lives, level, new_best} !== {8'd0, 2'd3, 4'd0, 1'b0}) begin bad++; $display("FAIL start.values got score=%0d lives=%0d level=%0d nb=%b", score, lives, level, new_best); end
  endtask

  task automatic hit(input logic [2:0] pattern);
    correct = pattern; game_over = 3'd0; tick();
    m_score = (m_score + pop(pattern) > 255) ? 255 : m_score + pop(pattern);
    total++; if (score !== 8'(m_score)) begin bad++; $display("FAIL hit.score got=%0d exp=%0d", score, m_score); end
    total++; if ({playing, over, reset_signal} !== 3'b100) begin bad++; $display("FAIL hit.point got=%b exp=100", {playing, over, reset_signal}); end
    correct = 3'($urandom); game_over = 3'($urandom); tick();
    correct = 3'd0; game_over = 3'd0;
    total++; if (score !== 8'(m_score)) begin bad++; $display("FAIL hit.ignored got=%0d exp=%0d", score, m_score); end
    total++; if (level !== 4'(exp_level())) begin bad++; $display("FAIL hit.level got=%0d exp=%0d", level, exp_level()); end
  endtask

  task automatic idle_cycle();
    correct = 3'd0; game_over = 3'd0; tick();
    total++; if ({playing, reset_signal, score, lives} !== {2'b10, 8'(m_score), 2'(m_lives)}) begin bad++; $display("FAIL idle.run got p=%b rs=%b score=%0d lives=%0d", playing, reset_signal, score, lives); end
  endtask

  task automatic miss(input logic [2:0] go, input logic [2:0] cor, input bit keep_start);
    game_over = go; correct = cor; tick();
    m_lives--;
    game_over = 3'd0; correct = 3'd0;
    total++; if ({playing, over, reset_signal} !== 3'b101) begin bad++; $display("FAIL miss.state got=%b exp=101", {playing, over, reset_signal}); end
    total++; if ({lives, score} !== {2'(m_lives), 8'(m_score)}) begin bad++; $display("FAIL miss.values got lives=%0d score=%0d exp %0d/%0d", lives, score, m_lives, m_score); end
    tick();
    if (m_lives == 0) begin
      m_new_best = (m_score > m_best);
      if (m_new_best) m_best = m_score;
      total++; if ({playing, over, reset_signal} !== 3'b010) begin bad++; $display("FAIL over.state got=%b exp=010", {playing, over, reset_signal}); end
      total++; if ({best_score, new_best, score} !== {8'(m_best), m_new_best, 8'(m_score)}) begin bad++; $display("FAIL over.best got best=%0d nb=%b score=%0d exp %0d/%b/%0d", best_score, new_best, score, m_best, m_new_best, m_score); end
      for (int k = 1; k < OVER_HOLD; k++) begin
        start = 1'b1; tick();
        total++; if ({playing, over} !== 2'b01) begin bad++; $display("FAIL over.hold%0d got=%b exp=01", k, {playing, over}); end
      end
      start = keep_start; tick();
      total++; if ({playing, over, reset_signal} !== 3'b000) begin bad++; $display("FAIL over.idle got=%b exp=000", {playing, over, reset_signal}); end
      total++; if ({score, best_score, new_best} !== {8'(m_score), 8'(m_best), m_new_best}) begin bad++; $display("FAIL idle.display got score=%0d best=%0d nb=%b", score, best_score, new_best); end
    end else begin
      total++; if ({playing, reset_signal, lives} !== {2'b10, 2'(m_lives)}) begin bad++; $display("FAIL miss.return got p=%b rs=%b lives=%0d exp lives=%0d", playing, reset_signal, lives, m_lives); end
    end
  endtask

  task automatic test_multi_hit();
    hit(3'b101);
    hit(3'b111);
    idle_cycle();
  endtask

  task automatic test_game_over();
    miss(3'b010, 3'b001, 1'b0);
    miss(3'b100, 3'b000, 1'b0);
    miss(3'b001, 3'b110, 1'b0);
  endtask

  task automatic test_back_to_back();
    begin_game();
    hit(3'b101);
    miss(3'b111, 3'b000, 1'b0);
    miss(3'b010, 3'b101, 1'b0);
    miss(3'b100, 3'b011, 1'b1);
    begin_game();
  endtask

  task automatic test_random();
    for (int g = 0; g < 4; g++) begin
      if (g != 0) begin_game();
      while (m_lives > 0) begin
        int act;
        act = $urandom_range(0, 9);
        if (act < 6)      hit(3'($urandom_range(1, 7)));
        else if (act < 8) idle_cycle();
        else              miss(3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), 1'b0);
      end
    end
  endtask

  task automatic test_saturation_reset();
    begin_game();
    for (int i = 0; i < 90; i++) hit(3'b111);
    total++; if ({score, level} !== {8'd255, 4'd15}) begin bad++; $display("FAIL sat.value got=%0d/%0d exp=255/15", score, level); end
    reset_button = 1'b1; tick();
    reset_button = 1'b0;
    total++; if ({playing, over, reset_signal} !== 3'b000) begin bad++; $display("FAIL midreset.state got=%b exp=000", {playing, over, reset_signal}); end
    total++; if ({score, best_score, lives, level} !== {8'd0, 8'd0, 2'd3, 4'd0}) begin bad++; $display("FAIL midreset.values got score=%0d best=%0d lives=%0d level=%0d", score, best_score, lives, level); end
  endtask

  initial begin
    test_reset();
    begin_game();
    test_multi_hit();
    test_game_over();
    test_back_to_back();
    test_random();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
